// File: rtl/btn_pkg.sv
// Shared definitions for push-button input blocks: FSM encoding and
// timing defaults for a 12 MHz board clock plus short simulation values.
package btn_pkg;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      ARM_PRESS   = 2'd1,
      HELD        = 2'd2,
      ARM_RELEASE = 2'd3
   } state_t;

   localparam int          BTN_CNT_WIDTH    = 24;
   localparam logic [23:0] DEBOUNCE_12MHZ   = 24'd120000;   // 10 ms
   localparam logic [23:0] LONG_PRESS_12MHZ = 24'd6000000;  // 0.5 s
   localparam logic [23:0] DEBOUNCE_SIM     = 24'd4;
   localparam logic [23:0] LONG_PRESS_SIM   = 24'd16;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous pin inputs; the reset
// value lets each pin start at its inactive level.
module sync_2ff #(
   parameter logic RESET_VALUE = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [1:0] stages;

   // NOTE: flops use non-blocking assignments so both stages sample the
   // pre-edge values; blocking here would collapse the chain to one flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stages <= {2{RESET_VALUE}};
      end else begin
         stages <= {stages[0], d};
      end
   end

   assign q = stages[1];

endmodule

// File: rtl/button_reader.sv
// Push-button front end: synchronizes and debounces one raw pin, emits
// press / release / long-press pulses and keeps a wrapping press counter.
module button_reader
   import btn_pkg::*;
#(
   parameter int                   CNT_WIDTH      = BTN_CNT_WIDTH,
   parameter logic [CNT_WIDTH-1:0] DEBOUNCE       = DEBOUNCE_12MHZ,
   parameter logic [CNT_WIDTH-1:0] LONG_PRESS     = LONG_PRESS_12MHZ,
   parameter int                   OUTPUT_SIZE    = 4,
   parameter bit                   BTN_ACTIVE_LOW = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   btn_raw,
   output logic                   btn_level,
   output logic                   press,
   output logic                   release_pulse,  // 'release' is a reserved word
   output logic                   long_press,
   output logic [OUTPUT_SIZE-1:0] press_count
);

   localparam logic [CNT_WIDTH-1:0]   TMR_ONE = CNT_WIDTH'(1);
   localparam logic [OUTPUT_SIZE-1:0] CNT_ONE = OUTPUT_SIZE'(1);

   logic                   sync_q;
   logic                   s;
   state_t                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   deb_q, deb_d;
   logic [CNT_WIDTH-1:0]   hold_q, hold_d;
   logic [CNT_WIDTH-1:0]   hold_sat;
   logic                   long_done_q, long_done_d;
   logic                   long_hit;
   logic                   press_d, release_d, long_d;
   logic [OUTPUT_SIZE-1:0] count_d;

   sync_2ff #(
      .RESET_VALUE (BTN_ACTIVE_LOW)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (btn_raw),
      .q     (sync_q)
   );

   assign s        = BTN_ACTIVE_LOW ? ~sync_q : sync_q;
   assign hold_sat = (hold_q == '1) ? hold_q : hold_q + TMR_ONE;
   // Latch guarantees one long_press per press even across release bounces.
   assign long_hit = (hold_sat == LONG_PRESS) && !long_done_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         deb_q         <= '0;
         hold_q        <= '0;
         long_done_q   <= 1'b0;
         press         <= 1'b0;
         release_pulse <= 1'b0;
         long_press    <= 1'b0;
         press_count   <= '0;
      end else begin
         state_q       <= state_d;
         deb_q         <= deb_d;
         hold_q        <= hold_d;
         long_done_q   <= long_done_d;
         press         <= press_d;
         release_pulse <= release_d;
         long_press    <= long_d;
         press_count   <= count_d;
      end
   end

   // NOTE: every signal gets its hold value first, so paths that do not
   // assign it cannot infer a latch.
   always_comb begin
      state_d     = state_q;
      deb_d       = deb_q;
      hold_d      = hold_q;
      long_done_d = long_done_q;
      unique case (state_q)
         IDLE: begin
            if (s) begin
               state_d = ARM_PRESS;
               deb_d   = TMR_ONE;
            end
         end
         ARM_PRESS: begin
            if (!s) begin
               state_d = IDLE;
               deb_d   = '0;
            end else if (deb_q == DEBOUNCE) begin
               state_d = HELD;
               deb_d   = '0;
            end else begin
               deb_d = deb_q + TMR_ONE;
            end
         end
         HELD: begin
            if (!s) begin
               state_d = ARM_RELEASE;
               deb_d   = TMR_ONE;
            end else begin
               hold_d = hold_sat;
               if (long_hit) long_done_d = 1'b1;
            end
         end
         ARM_RELEASE: begin
            if (s) begin
               state_d = HELD;
               deb_d   = '0;
            end else if (deb_q == DEBOUNCE) begin
               state_d     = IDLE;
               deb_d       = '0;
               hold_d      = '0;
               long_done_d = 1'b0;
            end else begin
               deb_d = deb_q + TMR_ONE;
            end
         end
      endcase
   end

   always_comb begin
      btn_level = (state_q == HELD) || (state_q == ARM_RELEASE);
      press_d   = (state_q == ARM_PRESS) && s && (deb_q == DEBOUNCE);
      release_d = (state_q == ARM_RELEASE) && !s && (deb_q == DEBOUNCE);
      long_d    = (state_q == HELD) && s && long_hit;
      count_d   = press_d ? press_count + CNT_ONE : press_count;
   end

endmodule
